// File: rtl/shift_pkg.sv
// Shared defaults and the result-entry layout for the shifter result buffer.
package shift_pkg;

   localparam int N_DEF     = 8;
   localparam int DEPTH_DEF = 4;
   localparam int CW_DEF    = 4;

   typedef struct packed {
      logic             err;
      logic             ovf;
      logic [N_DEF-1:0] data;
   } shift_res_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic show-ahead synchronous FIFO; occupancy count decides full/empty.
module sync_fifo #(
   parameter int  DEPTH = 4,
   parameter type T     = logic [7:0],
   localparam int AW    = $clog2(DEPTH),
   localparam int CNTW  = AW + 1
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            push_i,
   input  T                wdata_i,
   input  logic            pop_i,
   output T                rdata_o,
   output logic            full_o,
   output logic            empty_o,
   output logic [CNTW-1:0] count_o
);

   T                mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNTW-1:0] count_q, count_d;
   logic            do_push, do_pop;

   assign full_o  = (count_q == CNTW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];

   // A full FIFO refuses pushes even when a pop happens in the same cycle.
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNTW'(1);
         2'b01:   count_d = count_q - CNTW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i && do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/shift_result_fifo.sv
// Buffers shifter results in order and tracks sticky err/ovf status plus a
// saturating error counter for diagnostics.
module shift_result_fifo
   import shift_pkg::*;
#(
   parameter int N     = N_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int CW    = CW_DEF
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_valid,
   output logic                     o_ready,
   input  logic [N-1:0]             i_data,
   input  logic                     i_err,
   input  logic                     i_ovf,
   output logic                     o_valid,
   input  logic                     i_ready,
   output logic [N-1:0]             o_data,
   output logic                     o_err,
   output logic                     o_ovf,
   output logic [$clog2(DEPTH):0]   o_count,
   input  logic                     i_clr_sticky,
   output logic                     o_sticky_err,
   output logic                     o_sticky_ovf,
   output logic [CW-1:0]            o_err_cnt
);

   typedef struct packed {
      logic         err;
      logic         ovf;
      logic [N-1:0] data;
   } entry_t;

   entry_t        wr_entry, head;
   logic          full, empty, push, pop;
   logic          sticky_err_q, sticky_err_d;
   logic          sticky_ovf_q, sticky_ovf_d;
   logic [CW-1:0] err_cnt_q, err_cnt_d, err_cnt_base;

   assign wr_entry = '{err: i_err, ovf: i_ovf, data: i_data};
   assign o_ready  = ~full;
   assign o_valid  = ~empty;
   assign push     = i_valid & ~full;
   assign pop      = ~empty & i_ready;

   sync_fifo #(.DEPTH(DEPTH), .T(entry_t)) u_fifo (
      .clk_i   (i_clk),
      .rst_i   (i_rst),
      .push_i  (push),
      .wdata_i (wr_entry),
      .pop_i   (pop),
      .rdata_o (head),
      .full_o  (full),
      .empty_o (empty),
      .count_o (o_count)
   );

   // Stale storage must never leak out while empty.
   assign o_data = empty ? '0 : head.data;
   assign o_err  = empty ? 1'b0 : head.err;
   assign o_ovf  = empty ? 1'b0 : head.ovf;

   // Clear is applied first so a same-cycle set wins.
   always_comb begin
      sticky_err_d = (sticky_err_q & ~i_clr_sticky) | (push & i_err);
      sticky_ovf_d = (sticky_ovf_q & ~i_clr_sticky) | (push & i_ovf);
      err_cnt_base = i_clr_sticky ? '0 : err_cnt_q;
      err_cnt_d    = err_cnt_base;
      if (push && i_err && (err_cnt_base != {CW{1'b1}}))
         err_cnt_d = err_cnt_base + CW'(1);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sticky_err_q <= 1'b0;
         sticky_ovf_q <= 1'b0;
         err_cnt_q    <= '0;
      end else begin
         sticky_err_q <= sticky_err_d;
         sticky_ovf_q <= sticky_ovf_d;
         err_cnt_q    <= err_cnt_d;
      end
   end

   assign o_sticky_err = sticky_err_q;
   assign o_sticky_ovf = sticky_ovf_q;
   assign o_err_cnt    = err_cnt_q;

endmodule
